// File: rtl/descriptor_ram_pkg.sv
// Shared types, default geometry and parameter helpers for the dual-port descriptor RAM.
package descriptor_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int DATA_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT = 11;

    localparam int DEPTH = 2 ** ADDR_W_DEFAULT;
    localparam int BE_W  = DATA_W_DEFAULT / 8;

    function automatic int calc_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

    function automatic int calc_be_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic bit read_latency_legal(input int latency);
        return (latency == 1) || (latency == 2);
    endfunction

endpackage

// File: rtl/dp_ram_be.sv
// True dual-port byte-enabled storage array, read-first on both ports, registered read output.
module dp_ram_be
    import descriptor_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [ADDR_W-1:0]      a_addr,
    input  logic                   a_we,
    input  logic                   a_re,
    input  logic [DATA_W/8-1:0]    a_be,
    input  logic [DATA_W-1:0]      a_wdata,
    output logic [DATA_W-1:0]      a_rdata,
    input  logic [ADDR_W-1:0]      b_addr,
    input  logic                   b_we,
    input  logic                   b_re,
    input  logic [DATA_W/8-1:0]    b_be,
    input  logic [DATA_W-1:0]      b_wdata,
    output logic [DATA_W-1:0]      b_rdata
);

    localparam int LANES = calc_be_w(DATA_W);
    localparam int WORDS = calc_depth(ADDR_W);

    logic [LANES-1:0][7:0] mem [WORDS];

    // Port A lanes are written after port B so that A wins any lane both ports touch.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (b_we && b_be[i]) begin
                    mem[b_addr][i] <= b_wdata[8*i +: 8];
                end
                if (a_we && a_be[i]) begin
                    mem[a_addr][i] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if (en) begin
            if (a_re) begin
                a_rdata <= mem[a_addr];
            end
            if (b_re) begin
                b_rdata <= mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/descriptor_ram_dp.sv
// Dual-port descriptor memory: CPU on s1, SG-DMA on s2, with post-reset zero-fill sequencer
// and a configurable 1- or 2-cycle readdatavalid pipeline.
module descriptor_ram_dp
    import descriptor_ram_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clken,
    input  logic [ADDR_W-1:0]      s1_address,
    input  logic                   s1_chipselect,
    input  logic                   s1_read,
    input  logic                   s1_write,
    input  logic [DATA_W/8-1:0]    s1_byteenable,
    input  logic [DATA_W-1:0]      s1_writedata,
    output logic [DATA_W-1:0]      s1_readdata,
    output logic                   s1_readdatavalid,
    output logic                   s1_waitrequest,
    input  logic [ADDR_W-1:0]      s2_address,
    input  logic                   s2_chipselect,
    input  logic                   s2_read,
    input  logic                   s2_write,
    input  logic [DATA_W/8-1:0]    s2_byteenable,
    input  logic [DATA_W-1:0]      s2_writedata,
    output logic [DATA_W-1:0]      s2_readdata,
    output logic                   s2_readdatavalid,
    output logic                   s2_waitrequest,
    output logic                   init_done
);

    generate
        if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
            $error("descriptor_ram_dp: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    seq_state_t        state;
    logic [ADDR_W-1:0] fill_cnt;
    logic              filling;

    logic s1_accept, s1_wr, s1_rd;
    logic s2_accept, s2_wr, s2_rd;
    logic wr_collide;

    logic [ADDR_W-1:0]   ram_a_addr;
    logic                ram_a_we;
    logic [DATA_W/8-1:0] ram_a_be;
    logic [DATA_W-1:0]   ram_a_wdata;
    logic [DATA_W/8-1:0] ram_b_be;
    logic [DATA_W-1:0]   s1_q, s2_q;
    logic                s1_v1, s2_v1;

    // Sequencer: one zero word per enabled cycle, counter parks at the last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            fill_cnt  <= '0;
            init_done <= 1'b0;
        end else if (clken) begin
            case (state)
                INIT: begin
                    if ((INIT_ZERO == 0) || (&fill_cnt)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + ADDR_W'(1);
                    end
                end
                RUN: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign filling = (state == INIT) && (INIT_ZERO != 0);

    assign s1_waitrequest = (state != RUN) | ~clken;
    assign s2_waitrequest = (state != RUN) | ~clken;

    assign s1_accept = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
    assign s2_accept = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
    assign s1_wr     = s1_accept & s1_write;
    assign s2_wr     = s2_accept & s2_write;
    assign s1_rd     = s1_accept & s1_read & ~s1_write;
    assign s2_rd     = s2_accept & s2_read & ~s2_write;

    // On a same-address double write s2 keeps only the lanes s1 leaves untouched.
    assign wr_collide = s1_wr & s2_wr & (s1_address == s2_address);
    assign ram_b_be   = wr_collide ? (s2_byteenable & ~s1_byteenable) : s2_byteenable;

    assign ram_a_addr  = filling ? fill_cnt : s1_address;
    assign ram_a_we    = filling | s1_wr;
    assign ram_a_be    = filling ? '1 : s1_byteenable;
    assign ram_a_wdata = filling ? '0 : s1_writedata;

    dp_ram_be #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (clken),
        .a_addr  (ram_a_addr),
        .a_we    (ram_a_we),
        .a_re    (s1_rd),
        .a_be    (ram_a_be),
        .a_wdata (ram_a_wdata),
        .a_rdata (s1_q),
        .b_addr  (s2_address),
        .b_we    (s2_wr),
        .b_re    (s2_rd),
        .b_be    (ram_b_be),
        .b_wdata (s2_writedata),
        .b_rdata (s2_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v1 <= 1'b0;
            s2_v1 <= 1'b0;
        end else if (clken) begin
            s1_v1 <= s1_rd;
            s2_v1 <= s2_rd;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_W-1:0] s1_stage, s2_stage;
            logic              s1_v2, s2_v2;

            // Second stage only captures when stage one carries a real read, so data holds.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_stage <= '0;
                    s2_stage <= '0;
                    s1_v2    <= 1'b0;
                    s2_v2    <= 1'b0;
                end else if (clken) begin
                    s1_v2 <= s1_v1;
                    s2_v2 <= s2_v1;
                    if (s1_v1) begin
                        s1_stage <= s1_q;
                    end
                    if (s2_v1) begin
                        s2_stage <= s2_q;
                    end
                end
            end

            assign s1_readdata      = s1_stage;
            assign s2_readdata      = s2_stage;
            assign s1_readdatavalid = s1_v2;
            assign s2_readdatavalid = s2_v2;
        end else begin : g_lat1
            assign s1_readdata      = s1_q;
            assign s2_readdata      = s2_q;
            assign s1_readdatavalid = s1_v1;
            assign s2_readdatavalid = s2_v1;
        end
    endgenerate

endmodule

// File: doc/descriptor_ram_dp.md
Name: descriptor_ram_dp

Overview:
Parametrised dual-port on-chip descriptor memory. It serves two independent Avalon-MM slaves: s1 for the CPU and s2 for the SG-DMA descriptor fetch/writeback. Unlike the single-port generation, it adds:
- configurable width, depth and read latency;
- readdatavalid pipelining;
- defined cross-port collision rules;
- a post-reset zero-fill sequencer that guarantees no stale descriptors after reset.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 11, word address width; DEPTH = 2**ADDR_W.
READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values are 1 and 2.
INIT_ZERO, 1, 1 = zero-fill all words after reset; 0 = skip fill (contents undefined).

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous, active-low reset
clken  in  1  global clock enable; 0 freezes RAM, pipeline and sequencer
s1_address / s2_address  in  ADDR_W  word address per port
s1_chipselect / s2_chipselect  in  1  port select
s1_read / s2_read  in  1  read request
s1_write / s2_write  in  1  write request
s1_byteenable / s2_byteenable  in  DATA_W/8  per-byte write lanes
s1_writedata / s2_writedata  in  DATA_W  write data
s1_readdata / s2_readdata  out  DATA_W  read data, valid only with readdatavalid
s1_readdatavalid / s2_readdatavalid  out  1  one-cycle read-data strobe
s1_waitrequest / s2_waitrequest  out  1  1 = request not accepted this cycle
init_done  out  1  1 once zero-fill is complete; sticky until reset

Behaviour:
- Reset values (asynchronous, while reset_n = 0):
  - readdata = 0, readdatavalid = 0, waitrequest = 1, init_done = 0;
  - sequencer state = INIT, fill counter = 0.
- Sequencer state INIT:
  - writes 0 to address counter, all lanes, one word per clken cycle;
  - counter increments 0..DEPTH-1; after DEPTH-1 is written, next state is RUN;
  - fill takes exactly DEPTH enabled cycles;
  - if INIT_ZERO = 0, INIT lasts one cycle with no write.
- Sequencer state RUN: init_done = 1. There is no exit from RUN except reset.
- Reset asserted mid-INIT or mid-RUN:
  - immediate return to INIT with counter = 0;
  - in-flight reads are discarded and no readdatavalid is emitted.
- waitrequest_x = (state != RUN) | ~clken. It is combinational from state and clken only, and never depends on the request.
- Accept condition: accept_x = chipselect_x & (read_x | write_x) & ~waitrequest_x.
- Write (accept & write):
  - updates only the lanes whose byteenable bit is set;
  - byteenable = 0 is a no-op;
  - no readdatavalid is produced.
- Read/write conflict on one port: if read_x and write_x are both asserted, the write is performed and the read is ignored.
- Read (accept & read & ~write):
  - readdatavalid_x pulses exactly READ_LATENCY enabled cycles after accept;
  - readdata_x carries the word as it was before any same-cycle write;
  - readdata holds its last value between strobes.
- Pipelining:
  - back-to-back reads are accepted every cycle;
  - the readdatavalid stream mirrors the accept stream delayed by READ_LATENCY.
- clken = 0 freezes everything: valid pipeline, readdata, sequencer counter and RAM. No strobe is lost or duplicated.
- Same-address writes from both ports in the same cycle:
  - per byte lane, s1 wins where both byteenables are set;
  - lanes enabled only by s2 take s2 data.
- Cross-port read-during-write, same address: the reading port returns old data (read-first) on both ports.
- Address arithmetic: the counter is ADDR_W bits and stops at DEPTH-1 with no wrap into RUN writes. Port addresses are used unmodified.
- The storage array is behavioural RTL inferred as true dual-port block RAM. It carries no vendor primitive and no init file.

Decomposition:
- Shared package descriptor_ram_pkg:
  - sequencer state enum {INIT, RUN};
  - localparams DEPTH and BE_W = DATA_W/8;
  - READ_LATENCY legality check.
- One sub-module, dp_ram_be:
  - pure true-dual-port, byte-enabled, read-first array with 1-cycle registered output;
  - the top level adds the optional second output stage, sequencer, valid pipelines and collision merge.

Test Plan:
1. Release reset_n, clken = 1, defaults (DEPTH 2048) -> waitrequest high for exactly 2048 cycles, then init_done = 1. An s1 read of address 2047 returns 0x00000000 with readdatavalid 1 cycle after accept.
2. s1 writes 0xDEADBEEF, byteenable 4'b0101, to address 5, then s2 reads address 5 -> 0x00AD00EF.
3. Same cycle, address 7: s1 writes 0x11111111 with be 4'b0011, s2 writes 0x22222222 with be 4'b1111 -> a later read returns 0x22221111.
4. Address 9 holds 0xA5A5A5A5; s1 writes 0x5A5A5A5A while s2 reads 9 in the same cycle -> s2 gets 0xA5A5A5A5, and the next read gets 0x5A5A5A5A.
5. READ_LATENCY = 2: s2 issues 4 back-to-back reads at addresses 0..3 with clken dropped for 3 cycles mid-burst -> exactly 4 readdatavalid pulses, in order, each 2 enabled cycles after its accept.
6. Assert reset_n low at fill count 100 -> outputs go to reset values immediately. After release, fill restarts at 0 and init_done rises only after a full 2048 cycles.
